// File: rtl/alu_wb_regfile.sv
// Write-back stage: 2-entry result queue draining into an 8x16 register file with two read ports.
// Latency: accepted result lands in the register file one edge after accept (no stall); reads are combinational.
// Backpressure: in_ready drops when both queue slots are full or reset is high; wb_stall holds the drain.
//
// Ports:
//   clk, reset                    - clock; synchronous active-high reset
//   in_valid/in_ready             - result handshake; in_data/in_waddr carry the result and destination
//   wb_stall                      - when 1, the queue head is not written this cycle
//   rs_addr/rs_data, rt_addr/rt_data - combinational operand read ports (register 0 always reads 0)
//   wb_count, wb_busy             - registered queue occupancy (0..2) and occupancy != 0
//
// Optional macro WB_BYPASS_EN: read ports forward queued results (newest match wins) ahead of the
// register file. Without it, queued results are invisible until written.
module alu_wb_regfile #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic              wb_stall,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [1:0]        wb_count,
    output logic              wb_busy
);

    // Queue storage; validity is tracked solely by count, so slots need no reset.
    logic [ADDR_W-1:0] q_addr [2];
    logic [DATA_W-1:0] q_data [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic [DATA_W-1:0] regs [REG_CNT];

    logic              accept;
    logic              drain;

    // Ready is a pure function of state (plus reset), so a full queue stays not-ready
    // even on a cycle where the head drains.
    assign in_ready = !reset && (count != 2'd2);
    assign accept   = in_valid && in_ready;
    assign drain    = (count != 2'd0) && !wb_stall;

    assign wb_count = count;
    assign wb_busy  = (count != 2'd0);

    always_ff @(posedge clk) begin
        if (accept) begin
            q_addr[wr_ptr] <= in_waddr;
            q_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (drain) begin
                rd_ptr <= ~rd_ptr;
                // Writes to register 0 retire normally but leave it at zero.
                if (q_addr[rd_ptr] != '0) begin
                    regs[q_addr[rd_ptr]] <= q_data[rd_ptr];
                end
            end
            case ({accept, drain})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Both read ports share one lookup; index 0 is rs, index 1 is rt.
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    assign raddr[0] = rs_addr;
    assign raddr[1] = rt_addr;
    assign rs_data  = rdata[0];
    assign rt_data  = rdata[1];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = (raddr[p] == '0) ? '0 : regs[raddr[p]];
`ifdef WB_BYPASS_EN
            // Head first, then tail, so the newest matching entry takes precedence.
            if (raddr[p] != '0) begin
                if ((count != 2'd0) && (q_addr[rd_ptr] == raddr[p])) begin
                    rdata[p] = q_data[rd_ptr];
                end
                if ((count == 2'd2) && (q_addr[~rd_ptr] == raddr[p])) begin
                    rdata[p] = q_data[~rd_ptr];
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_wb_regfile.sv
module tb_alu_wb_regfile;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_waddr;
    logic        wb_stall;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [1:0]  wb_count;
    logic        wb_busy;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    alu_wb_regfile #(.DATA_W(16), .REG_CNT(8), .ADDR_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_waddr (in_waddr),
        .wb_stall (wb_stall),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wb_count (wb_count),
        .wb_busy  (wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One table step: inputs applied for one edge, outputs checked just after it.
    // rs/rt expectations come in two flavours: register file only, and with forwarding.
    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        stall;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [1:0]  e_cnt;
        logic        e_rdy;
        logic [15:0] e_rs;
        logic [15:0] e_rt;
        logic [15:0] e_rs_b;
        logic [15:0] e_rt_b;
    } vec_t;

    vec_t vecs [22];

    // Reference model for the random phase: ordered queue of pending writes plus an array.
    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        mq [$];
    logic [15:0] mregs [8];

    function automatic logic [15:0] model_read(input logic [2:0] a);
        logic [15:0] v;
        if (a == 3'd0) return 16'h0000;
        v = mregs[a];
        if (BYP) begin
            foreach (mq[i]) begin
                if (mq[i].a == a) v = mq[i].d;
            end
        end
        return v;
    endfunction

    task automatic step(input logic r, input logic v, input logic [2:0] wa, input logic [15:0] wd,
                        input logic s, input logic [2:0] ra, input logic [2:0] rb);
        reset    = r;
        in_valid = v;
        in_waddr = wa;
        in_data  = wd;
        wb_stall = s;
        rs_addr  = ra;
        rt_addr  = rb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_waddr = '0;
        wb_stall = 1'b0; rs_addr = '0; rt_addr = '0;

        //         rst vld wa   wd        stl rs  rt   cnt rdy  rs       rt       rs_byp   rt_byp
        // Single push to r3, written one edge later.
        vecs[0]  = '{1, 0, 3'd0, 16'h0000, 0, 3'd3, 3'd0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{0, 1, 3'd3, 16'hFFF0, 0, 3'd3, 3'd0, 1, 1, 16'h0000, 16'h0000, 16'hFFF0, 16'h0000};
        vecs[2]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd3, 3'd0, 0, 1, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000};
        // Stalled fill to two, third held, then ordered drain.
        vecs[3]  = '{0, 1, 3'd1, 16'h0101, 1, 3'd1, 3'd2, 1, 1, 16'h0000, 16'h0000, 16'h0101, 16'h0000};
        vecs[4]  = '{0, 1, 3'd2, 16'h0202, 1, 3'd1, 3'd2, 2, 0, 16'h0000, 16'h0000, 16'h0101, 16'h0202};
        vecs[5]  = '{0, 1, 3'd1, 16'h0303, 1, 3'd1, 3'd2, 2, 0, 16'h0000, 16'h0000, 16'h0101, 16'h0202};
        vecs[6]  = '{0, 1, 3'd1, 16'h0303, 0, 3'd1, 3'd2, 1, 1, 16'h0101, 16'h0000, 16'h0101, 16'h0202};
        vecs[7]  = '{0, 1, 3'd1, 16'h0303, 0, 3'd1, 3'd2, 1, 1, 16'h0101, 16'h0202, 16'h0303, 16'h0202};
        vecs[8]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd1, 3'd2, 0, 1, 16'h0303, 16'h0202, 16'h0303, 16'h0202};
        // Write to r0 retires but leaves zero.
        vecs[9]  = '{0, 1, 3'd0, 16'h1234, 0, 3'd0, 3'd0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[10] = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        // Two queued writes to r5: newer data wins.
        vecs[11] = '{0, 1, 3'd5, 16'hAAAA, 1, 3'd5, 3'd3, 1, 1, 16'h0000, 16'hFFF0, 16'hAAAA, 16'hFFF0};
        vecs[12] = '{0, 1, 3'd5, 16'h5555, 1, 3'd5, 3'd3, 2, 0, 16'h0000, 16'hFFF0, 16'h5555, 16'hFFF0};
        vecs[13] = '{0, 0, 3'd0, 16'h0000, 0, 3'd5, 3'd3, 1, 1, 16'hAAAA, 16'hFFF0, 16'h5555, 16'hFFF0};
        vecs[14] = '{0, 0, 3'd0, 16'h0000, 0, 3'd5, 3'd3, 0, 1, 16'h5555, 16'hFFF0, 16'h5555, 16'hFFF0};
        // Count 1 with simultaneous accept and drain.
        vecs[15] = '{0, 1, 3'd6, 16'h0006, 1, 3'd6, 3'd7, 1, 1, 16'h0000, 16'h0000, 16'h0006, 16'h0000};
        vecs[16] = '{0, 1, 3'd7, 16'h0007, 0, 3'd6, 3'd7, 1, 1, 16'h0006, 16'h0000, 16'h0006, 16'h0007};
        vecs[17] = '{0, 0, 3'd0, 16'h0000, 0, 3'd6, 3'd7, 0, 1, 16'h0006, 16'h0007, 16'h0006, 16'h0007};
        // Reset with two pending writes discards them and clears the file.
        vecs[18] = '{0, 1, 3'd2, 16'hBEEF, 1, 3'd2, 3'd4, 1, 1, 16'h0202, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[19] = '{0, 1, 3'd4, 16'hCAFE, 1, 3'd2, 3'd4, 2, 0, 16'h0202, 16'h0000, 16'hBEEF, 16'hCAFE};
        vecs[20] = '{1, 0, 3'd0, 16'h0000, 0, 3'd2, 3'd4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[21] = '{0, 0, 3'd0, 16'h0000, 0, 3'd2, 3'd4, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].wa, vecs[i].wd, vecs[i].stall, vecs[i].rs, vecs[i].rt);
            check($sformatf("vec%0d_count", i), {14'd0, wb_count}, {14'd0, vecs[i].e_cnt});
            check($sformatf("vec%0d_busy", i), {15'd0, wb_busy}, {15'd0, vecs[i].e_cnt != 2'd0});
            check($sformatf("vec%0d_ready", i), {15'd0, in_ready}, {15'd0, vecs[i].e_rdy});
            check($sformatf("vec%0d_rs", i), rs_data, BYP ? vecs[i].e_rs_b : vecs[i].e_rs);
            check($sformatf("vec%0d_rt", i), rt_data, BYP ? vecs[i].e_rt_b : vecs[i].e_rt);
        end

        // Register 3 was cleared by the reset above.
        step(0, 0, 3'd0, 16'h0, 0, 3'd3, 3'd0);
        check("post_reset_r3", rs_data, 16'h0000);

        // Random phase against the queue/array model; the DUT is in reset-clear state here.
        mq.delete();
        for (int r = 0; r < 8; r++) mregs[r] = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst;
            logic        r_vld;
            logic [2:0]  r_wa;
            logic [15:0] r_wd;
            logic        r_stl;
            logic [2:0]  r_rs;
            logic [2:0]  r_rt;
            logic        acc;
            logic        drn;
            ent_t        e;
            r_rst = ($urandom_range(0, 99) == 0);
            r_vld = $urandom_range(0, 2) != 0;
            r_wa  = 3'($urandom_range(0, 7));
            r_wd  = 16'($urandom);
            r_stl = $urandom_range(0, 2) == 0;
            r_rs  = 3'($urandom_range(0, 7));
            r_rt  = 3'($urandom_range(0, 7));
            acc = !r_rst && r_vld && (mq.size() < 2);
            drn = (mq.size() != 0) && !r_stl;
            step(r_rst, r_vld, r_wa, r_wd, r_stl, r_rs, r_rt);
            if (r_rst) begin
                mq.delete();
                for (int r = 0; r < 8; r++) mregs[r] = 16'h0000;
            end else begin
                if (drn) begin
                    e = mq.pop_front();
                    if (e.a != 3'd0) mregs[e.a] = e.d;
                end
                if (acc) begin
                    e.a = r_wa;
                    e.d = r_wd;
                    mq.push_back(e);
                end
            end
            check("rnd_count", {14'd0, wb_count}, 16'(mq.size()));
            check("rnd_busy", {15'd0, wb_busy}, {15'd0, mq.size() != 0});
            check("rnd_ready", {15'd0, in_ready}, {15'd0, !r_rst && (mq.size() < 2)});
            check("rnd_rs", rs_data, model_read(r_rs));
            check("rnd_rt", rt_data, model_read(r_rt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_wb_regfile.md
Name: alu_wb_regfile

Overview:
Write-back stage directly downstream of the 16-bit ALU logic units (NOT/AND/OR/ADD). Accepts ALU results and destination addresses over a valid/ready handshake and queues them in a 2-entry FIFO. Drains one entry per cycle into an 8 x 16-bit register file. The register file supplies the two operand read ports (rs/rt) that feed the ALU inputs.

Parameters:
DATA_W, 16, data width of results and registers
REG_CNT, 8, number of architectural registers
ADDR_W, 3, register address width; must equal log2(REG_CNT)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept a result this cycle
in_data  input  DATA_W  ALU result
in_waddr  input  ADDR_W  destination register
wb_stall  input  1  blocks drain when 1 (register-file port held by another writer)
rs_addr  input  ADDR_W  read port A address
rt_addr  input  ADDR_W  read port B address
rs_data  output  DATA_W  read port A data, combinational
rt_data  output  DATA_W  read port B data, combinational
wb_count  output  2  FIFO occupancy, 0..2
wb_busy  output  1  1 when wb_count != 0

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high.
- Reset (sampled high at a clock edge):
  - FIFO occupancy = 0; all registers = 0; wb_count = 0; wb_busy = 0.
  - in_ready is 0 while reset is high and 1 on the first cycle after reset is released.
- Reset mid-operation discards all queued entries. No partial register write occurs on that edge.
- in_ready = (wb_count < 2). It depends only on state, never on in_valid or wb_stall. At count 2, in_ready = 0 even if a drain happens that cycle.
- Accept: in_valid && in_ready at a clock edge pushes {in_waddr, in_data} at the tail.
- Drain: (wb_count != 0) && !wb_stall at a clock edge writes the head entry into the register file and pops it.
- Write latency: an entry accepted at edge N with no stall is written at edge N+1. Read ports show the new value from the cycle after edge N+1.
- Simultaneous accept and drain: occupancy is unchanged and order is preserved. With count 1, the head is written and the new entry becomes head.
- Register 0 is hardwired to zero:
  - writes to address 0 are accepted, queued and popped normally, but the register is not modified;
  - reads of address 0 always return 0.
- Reads:
  - rs_data/rt_data = regfile[addr], combinational.
  - Without the optional feature, queued (not yet written) entries are not visible.
- Write ordering: entries retire strictly in FIFO order. Two queued entries to the same address leave the later data in the register.
- Overflow is impossible because in_valid is ignored when in_ready = 0.
- Underflow is impossible because drain is gated by count != 0.
- wb_count/wb_busy are registered state outputs and reflect occupancy after the most recent edge.

Optional Feature:
Macro: WB_BYPASS_EN.
- Defined:
  - each read port forwards data from the FIFO when a queued entry's waddr matches the read address (address != 0);
  - if both entries match, the tail (newest) wins;
  - otherwise the register file value is returned;
  - read-after-write latency is 0 cycles after accept.
- Not defined: no forwarding; reads see only the register file, per Behaviour.

Test Plan:
1. Reset, then push in_data=16'hFFF0 to r3 with wb_stall=0 → r3 reads 16'hFFF0 two edges after the push. wb_count goes 1 then 0.
2. Hold wb_stall=1 and push 3 values → first two accepted, wb_count=2, in_ready=0, third held. Release the stall → drain order 1, 2, then the third is accepted.
3. Push 16'h1234 to r0 → wb_count goes 1 then 0, rs_addr=0 reads 16'h0000.
4. With wb_stall=1, push r5=16'hAAAA then r5=16'h5555, then release → r5 = 16'h5555. With WB_BYPASS_EN, rs_addr=5 reads 16'h5555 while both entries are queued; without it, reads 16'h0000 until drained.
5. With count=1, assert in_valid with no stall → simultaneous accept and drain, wb_count stays 1, data order preserved.
6. Assert reset with count=2 and pending writes → next cycle wb_count=0, all registers 0, no pending write lands.
